dht11_responder: RTL

DHT11_RESPONDER -- requirements
Module: dht11_responder

---
 rtl/dht11_responder_pkg.sv | 43 ++++
 rtl/dht11_tick_gen.sv | 28 ++
 rtl/dht11_responder.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/dht11_responder_pkg.sv
// Shared state encodings, phase lengths and helpers for the DHT11 sensor responder.
// The phase lengths are counted in 10 us ticks.
package dht11_responder_pkg;

   typedef enum logic [3:0] {
      StIdle     = 4'd0,
      StStartLow = 4'd1,
      StWaitRel  = 4'd2,
      StRespLow  = 4'd3,
      StRespHigh = 4'd4,
      StBitLow   = 4'd5,
      StBitHigh  = 4'd6,
      StEndLow   = 4'd7
   } dht_state_e;

   localparam int unsigned TicksWaitRel  = 3;
   localparam int unsigned TicksRespLow  = 8;
   localparam int unsigned TicksRespHigh = 8;
   localparam int unsigned TicksBitLow   = 5;
   localparam int unsigned TicksBitHigh0 = 3;
   localparam int unsigned TicksBitHigh1 = 7;
   localparam int unsigned TicksEndLow   = 5;

   localparam int unsigned FrameBits = 40;
   localparam int unsigned CntW      = 11;
   localparam int unsigned BitIdxW   = 6;

   // Checksum is the plain byte sum; the 8-bit result gives the mod-256 wrap.
   function automatic logic [7:0] frame_csum(input logic [7:0] a, input logic [7:0] b,
                                             input logic [7:0] c, input logic [7:0] d,
                                             input logic invert);
      logic [7:0] sum;
      sum = a + b + c + d;
      return invert ? ~sum : sum;
   endfunction

   // True on the tick that completes a phase of the given length.
   function automatic logic phase_end(input logic tick, input logic [CntW-1:0] cnt,
                                      input int unsigned ticks);
      return tick && (32'(cnt) == ticks - 1);
   endfunction

endpackage

// File: rtl/dht11_tick_gen.sv
// 10 us tick prescaler: one-cycle tick every F_CNT clocks, restartable via clr so
// that each FSM phase starts with a full tick period.
module dht11_tick_gen #(
   parameter int unsigned F_CNT = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int unsigned CW = (F_CNT > 1) ? $clog2(F_CNT) : 1;

   logic [CW-1:0] cnt_q;

   assign tick = (cnt_q == CW'(F_CNT - 1));

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_q <= '0;
      end else if (tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/dht11_responder.sv
// DHT11 sensor emulator: detects a host start pulse on the single-wire bus and answers
// with the response preamble followed by a 40-bit humidity/temperature frame.
module dht11_responder
   import dht11_responder_pkg::*;
#(
   parameter int unsigned F_CNT     = 1000,
   parameter int unsigned START_MIN = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rh_int,
   input  logic [7:0] rh_dec,
   input  logic [7:0] t_int,
   input  logic [7:0] t_dec,
   input  logic       corrupt_csum,
   output logic       busy,
   output logic       done,
   output logic [3:0] state,
   inout  wire        dht11_io
);

   dht_state_e             state_q, state_d;
   logic [1:0]             sync_q;
   logic                   line_prev_q;
   logic [CntW-1:0]        cnt_q;
   logic [BitIdxW-1:0]     bit_idx_q;
   logic [FrameBits-1:0]   frame_q;
   logic                   done_q;

   logic                   tick;
   logic                   clr;
   logic                   line;
   logic                   line_fall;
   logic                   line_rise;
   logic                   cur_bit;
   logic                   last_bit;
   int unsigned            bit_high_ticks;
   logic                   io_en;
   logic                   io_out;

   dht11_tick_gen #(
      .F_CNT(F_CNT)
   ) u_tick_gen (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .tick(tick)
   );

   assign line      = sync_q[1];
   assign line_fall = line_prev_q & ~line;
   assign line_rise = ~line_prev_q & line;

   assign cur_bit        = frame_q[BitIdxW'(FrameBits - 1) - bit_idx_q];
   assign last_bit       = (bit_idx_q == BitIdxW'(FrameBits - 1));
   assign bit_high_ticks = cur_bit ? TicksBitHigh1 : TicksBitHigh0;

   // Every state change restarts both the prescaler and the phase counter.
   assign clr = (state_d != state_q);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. Bus input is only consulted in states where io_en is low.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (line_fall) state_d = StStartLow;
         end
         StStartLow: begin
            if (line_rise) begin
               state_d = (32'(cnt_q) >= START_MIN) ? StWaitRel : StIdle;
            end
         end
         StWaitRel: begin
            if (phase_end(tick, cnt_q, TicksWaitRel)) state_d = StRespLow;
         end
         StRespLow: begin
            if (phase_end(tick, cnt_q, TicksRespLow)) state_d = StRespHigh;
         end
         StRespHigh: begin
            if (phase_end(tick, cnt_q, TicksRespHigh)) state_d = StBitLow;
         end
         StBitLow: begin
            if (phase_end(tick, cnt_q, TicksBitLow)) state_d = StBitHigh;
         end
         StBitHigh: begin
            if (phase_end(tick, cnt_q, bit_high_ticks)) begin
               state_d = last_bit ? StEndLow : StBitLow;
            end
         end
         StEndLow: begin
            if (phase_end(tick, cnt_q, TicksEndLow)) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs decoded from the current state only.
   always_comb begin
      io_en  = 1'b0;
      io_out = 1'b0;
      unique case (state_q)
         StRespLow, StBitLow, StEndLow: begin
            io_en  = 1'b1;
            io_out = 1'b0;
         end
         StRespHigh, StBitHigh: begin
            io_en  = 1'b1;
            io_out = 1'b1;
         end
         default: begin
            io_en  = 1'b0;
            io_out = 1'b0;
         end
      endcase
      busy  = !(state_q inside {StIdle, StStartLow});
      state = state_q;
      done  = done_q;
   end

   assign dht11_io = io_en ? io_out : 1'bz;

   // Datapath: synchronizer, phase counter, bit index, frame latch, done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q      <= '0;
         line_prev_q <= 1'b0;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         frame_q     <= '0;
         done_q      <= 1'b0;
      end else begin
         sync_q      <= {sync_q[0], dht11_io};
         line_prev_q <= sync_q[1];
         done_q      <= (state_q == StEndLow) && (state_d == StIdle);

         if (clr) begin
            cnt_q <= '0;
         end else if (tick && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
         end

         if (state_q == StRespHigh) begin
            bit_idx_q <= '0;
         end else if ((state_q == StBitHigh) && (state_d == StBitLow)) begin
            bit_idx_q <= bit_idx_q + 1'b1;
         end

         // Snapshot the payload once so later input changes cannot tear the frame.
         if ((state_q == StStartLow) && (state_d == StWaitRel)) begin
            frame_q <= {rh_int, rh_dec, t_int, t_dec,
                        frame_csum(rh_int, rh_dec, t_int, t_dec, corrupt_csum)};
         end
      end
   end

endmodule
